// File: rtl/trigger_pkg.sv
// Shared constants for the trigger sequencer: default sizes and FSM encodings.
package trigger_pkg;

  localparam int NE_DEF = 4;
  localparam int NS_DEF = 4;
  localparam int CW_DEF = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Width of a stage index; a single-stage sequencer still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trigger_sequencer.sv
// Multi-stage trigger sequencer: each stage waits for a programmable number
// of qualified comparator events, then hands off to the next stage; the final
// stage emits a one-cycle trigger pulse and latches sts_done.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int NE = NE_DEF,
  parameter int NS = NS_DEF,
  parameter int CW = CW_DEF,
  localparam int SW = idx_width(NS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ctl_arm,
  input  logic             ctl_abort,
  input  logic [NS*NE-1:0] cfg_msk,
  input  logic [NS*CW-1:0] cfg_cnt,
  input  logic [SW-1:0]    cfg_lst,
  input  logic             sti_transfer,
  input  logic [NE-1:0]    evt,
  output logic             sts_run,
  output logic [SW-1:0]    sts_stg,
  output logic             sts_done,
  output logic             trg
);

  logic [1:0]    state;
  logic [SW-1:0] stage;
  logic [CW-1:0] count;
  logic          q_xfer;

  logic [NS-1:0] stage_hit;
  logic          hit;
  logic [CW-1:0] cnt_tgt;
  logic [SW-1:0] lst_eff;
  logic          at_last;
  logic          at_tgt;

  // Per-stage event match; an all-zero mask matches every qualified cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_stage_hit
      assign stage_hit[gi] = (cfg_msk[gi*NE +: NE] == '0) ||
                             (|(evt & cfg_msk[gi*NE +: NE]));
    end
  endgenerate

  // Select the active stage's match and target; out-of-range last index clamps.
  always_comb begin
    hit     = q_xfer & stage_hit[stage];
    cnt_tgt = cfg_cnt[stage*CW +: CW];
    lst_eff = ({1'b0, cfg_lst} >= (SW+1)'(NS)) ? SW'(NS - 1) : cfg_lst;
    at_last = (stage == lst_eff);
    at_tgt  = (count == cnt_tgt);
  end

  // Sequencer FSM, stage/occurrence counters and the registered trigger pulse.
  // Events lag their transfer by a cycle, so hits are qualified by q_xfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      stage    <= '0;
      count    <= '0;
      q_xfer   <= 1'b0;
      trg      <= 1'b0;
      sts_done <= 1'b0;
    end else begin
      q_xfer <= sti_transfer;
      trg    <= 1'b0;
      if (ctl_abort) begin
        state    <= IDLE;
        stage    <= '0;
        count    <= '0;
        sts_done <= 1'b0;
      end else if (ctl_arm && state != RUN) begin
        state    <= RUN;
        stage    <= '0;
        count    <= '0;
        sts_done <= 1'b0;
      end else if (state == RUN && hit) begin
        if (!at_tgt) begin
          count <= count + 1'b1;
        end else if (!at_last) begin
          stage <= stage + 1'b1;
          count <= '0;
        end else begin
          state    <= DONE;
          trg      <= 1'b1;
          sts_done <= 1'b1;
        end
      end
    end
  end

  // Status view: stage index is only meaningful while running.
  always_comb begin
    sts_run = (state == RUN);
    sts_stg = sts_run ? stage : '0;
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer. Each cycle's stimulus is driven from a
// per-scenario table; a reference model pushes the expected outputs into a
// scoreboard queue, and the scenario pops and compares after the clock edge.
module tb_trigger_sequencer;

  localparam int NE = 4;
  localparam int NS = 4;
  localparam int CW = 16;

  // Stimulus code bits: {rst, arm, abort, xfer, evt[3:0]}
  localparam logic [7:0] C_R  = 8'h80;
  localparam logic [7:0] C_A  = 8'h40;
  localparam logic [7:0] C_B  = 8'h20;
  localparam logic [7:0] C_X  = 8'h10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ctl_arm = 1'b0;
  logic             ctl_abort = 1'b0;
  logic [NS*NE-1:0] cfg_msk = '0;
  logic [NS*CW-1:0] cfg_cnt = '0;
  logic [1:0]       cfg_lst = '0;
  logic             sti_transfer = 1'b0;
  logic [NE-1:0]    evt = '0;
  logic             sts_run;
  logic [1:0]       sts_stg;
  logic             sts_done;
  logic             trg;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         m_state = 0;
  logic [1:0] m_stg = '0;
  logic [15:0] m_cnt = '0;
  logic       m_q = 1'b0;
  logic       m_done = 1'b0;
  logic       m_trg = 1'b0;

  logic [4:0] exp_q[$];

  trigger_sequencer #(.NE(NE), .NS(NS), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ctl_arm(ctl_arm), .ctl_abort(ctl_abort),
    .cfg_msk(cfg_msk), .cfg_cnt(cfg_cnt), .cfg_lst(cfg_lst),
    .sti_transfer(sti_transfer), .evt(evt),
    .sts_run(sts_run), .sts_stg(sts_stg), .sts_done(sts_done), .trg(trg)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the model, push its expected outputs, clock.
  task automatic tick(input logic [7:0] c);
    logic [3:0]  msk;
    logic [15:0] tgt;
    logic        hit;
    rst          = c[7];
    ctl_arm      = c[6];
    ctl_abort    = c[5];
    sti_transfer = c[4];
    evt          = c[3:0];
    if (c[7]) begin
      m_state = 0; m_stg = '0; m_cnt = '0; m_q = 1'b0; m_done = 1'b0; m_trg = 1'b0;
    end else begin
      msk   = cfg_msk[m_stg*4 +: 4];
      tgt   = cfg_cnt[m_stg*16 +: 16];
      hit   = m_q && ((msk == 4'b0) || ((c[3:0] & msk) != 4'b0));
      m_trg = 1'b0;
      if (c[5]) begin
        m_state = 0; m_stg = '0; m_cnt = '0; m_done = 1'b0;
      end else if (c[6] && m_state != 1) begin
        m_state = 1; m_stg = '0; m_cnt = '0; m_done = 1'b0;
      end else if (m_state == 1 && hit) begin
        if (m_cnt != tgt) m_cnt = m_cnt + 16'd1;
        else if (m_stg != cfg_lst) begin m_stg = m_stg + 2'd1; m_cnt = '0; end
        else begin m_state = 2; m_done = 1'b1; m_trg = 1'b1; end
      end
      m_q = c[4];
    end
    exp_q.push_back({m_state == 1, (m_state == 1) ? m_stg : 2'b00, m_done, m_trg});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] obs;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {sts_run, sts_stg, sts_done, trg};
    checks++;
    if (obs !== 5'b0) begin
      failures++;
      $display("FAIL reset_state: run/stg/done/trg got=%b need=%b", obs, 5'b0);
    end
    tick(8'h00);
    obs = {sts_run, sts_stg, sts_done, trg};
    checks++;
    if (obs !== exp_q.pop_front()) begin
      failures++;
      $display("FAIL reset_release: run/stg/done/trg got=%b need=%b", obs, 5'b0);
    end
    $display("test_reset: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_single;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd0; cfg_msk = 16'h8421; cfg_cnt = '0;
    seq = '{C_A, 8'h00, C_X, 8'h01, 8'h00, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL single cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL single_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_single: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_count;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd0; cfg_msk = 16'h8421; cfg_cnt = '0;
    cfg_cnt[15:0] = 16'd2;
    seq = '{C_A, C_X, 8'h01, 8'h00, C_X, 8'h01, 8'h00, 8'h01, 8'h01, 8'h01,
            8'h00, C_X, 8'h01, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL count cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
      if (i == 10) begin
        checks++;
        if (ntrg !== 0) begin
          failures++;
          $display("FAIL count_early_trg: got=%0d need=0", ntrg);
        end
      end
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL count_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_count: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_multi;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd2; cfg_msk = 16'h0421; cfg_cnt = '0;
    seq = '{C_A, C_X, 8'h04, C_X, 8'h01, C_X, 8'h02, C_X, 8'h04, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL multi cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL multi_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_multi: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_arm_abort;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd2; cfg_msk = 16'h0421; cfg_cnt = '0;
    seq = '{C_A, C_X, 8'h01, C_B, C_A | C_B, 8'h00,
            C_A, C_X, 8'h01, C_A, C_X, 8'h02, C_X, 8'h04, 8'h00,
            C_A, C_X, 8'h01, C_X, 8'h02, C_X, C_B | 8'h04, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL arm_abort cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL arm_abort_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_arm_abort: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd2; cfg_msk = 16'h0421; cfg_cnt = '0;
    cfg_cnt[47:32] = 16'd1;
    seq = '{C_A, C_X, 8'h01, C_X, 8'h02, C_X, 8'h04,
            C_R, C_R, 8'h00, C_X, 8'h04, C_X, 8'h04, 8'h00,
            C_A, C_X, 8'h01, C_X, 8'h02, C_X, 8'h04, C_X, 8'h04, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_mid cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
      if (i == 14) begin
        checks++;
        if (ntrg !== 0) begin
          failures++;
          $display("FAIL reset_mid_stale_trg: got=%0d need=0", ntrg);
        end
      end
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL reset_mid_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_reset_mid: checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_mask0;
    logic [7:0] seq[$];
    logic [4:0] obs, expv;
    int ntrg = 0;
    cfg_lst = 2'd0; cfg_msk = 16'h4210; cfg_cnt = '0;
    cfg_cnt[15:0] = 16'd3;
    seq = '{C_A, C_X, 8'h00, C_X, 8'h08, C_X, 8'h00, 8'h00, C_X, 8'h0F, 8'h00};
    foreach (seq[i]) begin
      tick(seq[i]);
      obs = {sts_run, sts_stg, sts_done, trg};
      expv = exp_q.pop_front();
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL mask0 cyc%0d: run/stg/done/trg got=%b need=%b", i, obs, expv);
      end
      if (trg) ntrg++;
      if (i == 8) begin
        checks++;
        if (ntrg !== 0) begin
          failures++;
          $display("FAIL mask0_early_trg: got=%0d need=0", ntrg);
        end
      end
    end
    checks++;
    if (ntrg !== 1) begin
      failures++;
      $display("FAIL mask0_trg_count: got=%0d need=1", ntrg);
    end
    $display("test_mask0: checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    test_reset();
    test_single();
    test_count();
    test_multi();
    test_arm_abort();
    test_reset_mid();
    test_mask0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
